// File: rtl/spi_pkg.sv
// Shared defaults and state encoding for the SPI shift unit.
// Build option SPI_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
package spi_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int COUNTER_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_shift_core.sv
// Transmit/receive shift registers with bit-order selection.
// SPI_LSB_FIRST_EN defined: shift right, LSB on the wire first; otherwise MSB-first.
module spi_shift_core
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  counter_s_clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  mosi,
    output logic                  tx_bit,
    output logic [DATA_WIDTH-1:0] rx_word
);

    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_next;

    // rx_word is the register contents including the bit arriving this edge,
    // so the top can capture a full word on the last-bit edge.
`ifdef SPI_LSB_FIRST_EN
    assign tx_bit  = tx_shift_q[0];
    assign tx_next = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
    assign rx_word = {mosi, rx_shift_q[DATA_WIDTH-1:1]};
`else
    assign tx_bit  = tx_shift_q[DATA_WIDTH-1];
    assign tx_next = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], mosi};
`endif

    always_comb begin
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        if (load) begin
            tx_shift_d = tx_data;
        end else if (shift) begin
            tx_shift_d = tx_next;
            rx_shift_d = rx_word;
        end
    end

    always_ff @(posedge counter_s_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
        end else begin
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
        end
    end

endmodule

// File: rtl/spi_shift_unit.sv
// SPI frame shifter: IDLE/SHIFT/DONE control, frame capture and sticky error flags.
// Bit order is chosen by SPI_LSB_FIRST_EN inside spi_shift_core.
module spi_shift_unit
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF   // 2**COUNTER_WIDTH must exceed DATA_WIDTH
) (
    input  logic                  counter_s_clk,
    input  logic                  rst_n,
    input  logic                  done_tick,
    input  logic                  mosi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  sync_err
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(DATA_WIDTH - 1);

    spi_state_e             state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   sync_err_q, sync_err_d;
    logic                   done_first_q, done_first_d;
    logic                   load, shift;
    logic                   tx_bit;
    logic [DATA_WIDTH-1:0]  rx_word;

    spi_shift_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .counter_s_clk (counter_s_clk),
        .rst_n         (rst_n),
        .load          (load),
        .shift         (shift),
        .tx_data       (tx_data),
        .mosi          (mosi),
        .tx_bit        (tx_bit),
        .rx_word       (rx_word)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = overrun_q;
        sync_err_d   = sync_err_q;
        done_first_d = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_load) begin
                    load       = 1'b1;
                    cnt_d      = '0;
                    rx_valid_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tx_load) overrun_d = 1'b1;
                // An early frame-complete tick means the external counter and
                // ours have slipped; abandon the frame rather than guess.
                if (done_tick && (cnt_q != LAST_IDX)) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    shift = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        rx_data_d    = rx_word;
                        rx_valid_d   = 1'b1;
                        state_d      = ST_DONE;
                        done_first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (done_first_q && !done_tick) sync_err_d = 1'b1;
                if (tx_load) begin
                    load       = 1'b1;
                    cnt_d      = '0;
                    rx_valid_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge counter_s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            sync_err_q   <= sync_err_d;
            done_first_q <= done_first_d;
        end
    end

    assign miso     = busy_q ? tx_bit : 1'b1;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_spi_shift_unit.sv
// Directed bench for spi_shift_unit; expectations follow the build's bit order
// (SPI_LSB_FIRST_EN defined or not).
module tb_spi_shift_unit;

    logic       counter_s_clk = 1'b0;
    logic       rst_n         = 1'b0;
    logic       done_tick     = 1'b0;
    logic       mosi          = 1'b0;
    logic [7:0] tx_data       = 8'h00;
    logic       tx_load       = 1'b0;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid, busy, overrun, sync_err;

    int n_chk  = 0;
    int n_fail = 0;

    spi_shift_unit dut (
        .counter_s_clk (counter_s_clk),
        .rst_n         (rst_n),
        .done_tick     (done_tick),
        .mosi          (mosi),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .miso          (miso),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .busy          (busy),
        .overrun       (overrun),
        .sync_err      (sync_err)
    );

    always #5 counter_s_clk = ~counter_s_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // k-th bit on the wire (k=0 first) for the configured bit order
    function automatic logic wire_bit(input logic [7:0] w, input int k);
`ifdef SPI_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    task automatic edge1();
        @(posedge counter_s_clk);
        #1;
    endtask

    // Load tx, shift rx in. ovr_edge: shift edge (1-based) with tx_load also high.
    // err_edge: shift edge where done_tick fires early (frame abandoned).
    task automatic frame(input logic [7:0] tx, input logic [7:0] rx,
                         input int ovr_edge, input int err_edge, input logic tick_after);
        tx_data = tx; tx_load = 1'b1; done_tick = 1'b0;
        edge1();
        tx_load = 1'b0;
        chk("busy_after_load", busy, 1);
        chk("rx_valid_clr_on_load", rx_valid, 0);
        for (int k = 0; k < 8; k++) begin
            if (k + 1 == err_edge) begin
                done_tick = 1'b1;
                edge1();
                done_tick = 1'b0;
                chk("sync_err_early_tick", sync_err, 1);
                chk("idle_after_sync_err", busy, 0);
                chk("miso_idle_after_err", miso, 1);
                return;
            end
            chk($sformatf("miso_bit%0d", k), miso, wire_bit(tx, k));
            mosi    = wire_bit(rx, k);
            tx_load = (k + 1 == ovr_edge);
            edge1();
            tx_load = 1'b0;
        end
        chk("rx_data_frame", rx_data, rx);
        chk("rx_valid_frame", rx_valid, 1);
        chk("busy_done", busy, 0);
        chk("miso_done", miso, 1);
        chk("no_sync_err_at_capture", sync_err, 0);
        done_tick = tick_after;
        edge1();
        done_tick = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_miso", miso, 1);
        edge1();
        rst_n = 1'b1;
        edge1();
        chk("idle_miso", miso, 1);

        // Basic frame A5 out, 3C in
        frame(8'hA5, 8'h3C, 0, 0, 1'b1);
        chk("sync_ok_with_tick", sync_err, 0);
        edge1(); edge1();
        chk("rx_valid_sticky", rx_valid, 1);
        chk("rx_data_hold", rx_data, 8'h3C);

        // Back-to-back from DONE, with overrun at edge 4
        frame(8'h5A, 8'hC3, 4, 0, 1'b1);
        chk("overrun_set", overrun, 1);
        chk("sync_err_clean", sync_err, 0);

        // Early done_tick at edge 5
        frame(8'h11, 8'h77, 0, 5, 1'b1);
        chk("rx_data_kept_after_err", rx_data, 8'hC3);
        edge1();
        chk("idle_stays", busy, 0);

        // Reset after edge 3
        tx_data = 8'h96; tx_load = 1'b1;
        edge1();
        tx_load = 1'b0;
        for (int k = 0; k < 3; k++) begin mosi = 1'b1; edge1(); end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_sync_err", sync_err, 0);
        chk("mid_rst_miso", miso, 1);
        edge1();
        rst_n = 1'b1;
        // done_tick left low on the first DONE edge -> sync_err
        frame(8'hFF, 8'hFF, 0, 0, 1'b0);
        chk("sync_err_missing_tick", sync_err, 1);
        chk("overrun_still_clear", overrun, 0);

        // Single-bit word: first wire bit depends on bit order
        tx_data = 8'h01; tx_load = 1'b1;
        edge1();
        tx_load = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        chk("first_miso_01", miso, 1);
`else
        chk("first_miso_01", miso, 0);
`endif
        for (int k = 0; k < 8; k++) begin
            mosi = (k == 0);
            edge1();
        end
`ifdef SPI_LSB_FIRST_EN
        chk("rx_first_bit_word", rx_data, 8'h01);
`else
        chk("rx_first_bit_word", rx_data, 8'h80);
`endif
        chk("rx_valid_last", rx_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_shift_unit.md
SPI_SHIFT_UNIT -- requirements
Module: spi_shift_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, frame length in bits.
REQ-002 Parameter COUNTER_WIDTH, default 4, width of internal bit index; SHALL satisfy 2**COUNTER_WIDTH > DATA_WIDTH.
REQ-003 counter_s_clk  in  1  shift clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 done_tick  in  1  frame-complete flag from the bit counter, same clock domain.
REQ-006 mosi  in  1  serial receive data.
REQ-007 tx_data  in  DATA_WIDTH  word to transmit, sampled when a load is accepted.
REQ-008 tx_load  in  1  load request.
REQ-009 miso  out  1  serial transmit data.
REQ-010 rx_data  out  DATA_WIDTH  last complete received word.
REQ-011 rx_valid  out  1  rx_data holds a fresh word.
REQ-012 busy  out  1  high in SHIFT.
REQ-013 overrun  out  1  sticky: load requested while busy.
REQ-014 sync_err  out  1  sticky: done_tick disagreed with the internal bit index.

Function
REQ-015 States IDLE, SHIFT, DONE; IDLE->SHIFT on tx_load; SHIFT->DONE on capture of the last bit; DONE->SHIFT on tx_load; DONE otherwise holds.
REQ-016 Load accepted in IDLE or DONE when tx_load=1: tx_shift<=tx_data, bit index<=0, rx_valid<=0.
REQ-017 In SHIFT with done_tick=0, each edge: rx_shift<={rx_shift[W-2:0],mosi}, tx_shift<<=1, bit index+1.
REQ-018 On the edge where bit index==DATA_WIDTH-1 in SHIFT: rx_data<={rx_shift[W-2:0],mosi}, rx_valid<=1, state<=DONE; latency DATA_WIDTH edges from the first shift edge.
REQ-019 rx_valid stays high until the next accepted load or reset (the serial clock can stop after a frame).
REQ-020 miso=tx_shift[W-1] in SHIFT; miso=1 in IDLE and DONE.
REQ-021 tx_load=1 in SHIFT is ignored; overrun<=1.
REQ-022 done_tick=1 in SHIFT before the last-bit capture: no shift, sync_err<=1, state<=IDLE, rx_data unchanged.
REQ-023 done_tick=0 on the first edge in DONE: sync_err<=1, no other effect.
REQ-024 Bit index never exceeds DATA_WIDTH-1; no wrap-around.

Reset
REQ-025 rst_n=0 forces immediately: state IDLE, tx_shift=0, rx_shift=0, rx_data=0, rx_valid=0, busy=0, overrun=0, sync_err=0, miso=1.
REQ-026 Reset mid-frame discards partial data; the first edge after release behaves as IDLE.

Configuration
REQ-027 Macro SPI_LSB_FIRST_EN defined: tx_shift shifts right, miso=tx_shift[0], mosi enters rx_shift[W-1], rx_data assembled LSB-first.
REQ-028 Macro SPI_LSB_FIRST_EN undefined: MSB-first per REQ-017..REQ-020.

Structure
REQ-029 Shared package spi_pkg SHALL hold the DATA_WIDTH and COUNTER_WIDTH defaults and the IDLE/SHIFT/DONE state encoding.
REQ-030 One sub-module, spi_shift_core, SHALL hold the tx/rx shift registers and the bit-order selection; the FSM and flags stay in spi_shift_unit.

Verification
REQ-031 tx_data=8'hA5 loaded, mosi drives 8'h3C MSB-first, done_tick rising after the 8th edge -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1 after edge 8.
REQ-032 tx_load pulsed at edge 4 of a frame -> overrun=1, frame completes unchanged, rx_data correct.
REQ-033 done_tick forced high at edge 5 -> sync_err=1, state IDLE, rx_data holds its previous value.
REQ-034 rst_n low after edge 3 -> all outputs at reset values, miso=1; new frame 8'hFF -> rx_data=8'hFF.
REQ-035 SPI_LSB_FIRST_EN defined, tx_data=8'h01, mosi 1,0,0,0,0,0,0,0 -> miso first bit 1, rx_data=8'h01.
REQ-036 Back-to-back: load in DONE -> rx_valid clears on the load edge, second word received correctly.
